// File: rtl/mskunmask_seq_if.sv
// Handshake bundle for the serial share recombiner: masked word in, unmasked word out.
interface mskunmask_seq_if #(
   parameter int d = 2,
   parameter int W = 8
);
   logic           in_valid;
   logic           in_ready;
   logic [d*W-1:0] in_shares;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out_data;
   logic           busy;

   modport slave (
      input  in_valid, in_shares, out_ready,
      output in_ready, out_valid, out_data, busy
   );

   modport master (
      output in_valid, in_shares, out_ready,
      input  in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/mskunmask_seq.sv
// Serial unmasking of a d-share Boolean-masked word: the shares are captured,
// then XOR-folded into an accumulator one share per cycle, so no combinational
// path ever combines two shares of the same bit before a register.
module mskunmask_seq #(
   parameter int d = 2,
   parameter int W = 8
) (
   input logic            clk,
   input logic            rst,
   mskunmask_seq_if.slave bus
);
   localparam int CW = (d > 2) ? $clog2(d) : 1;

   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  sh_q [d];
   logic [W-1:0]  sh_d [d];
   logic [W-1:0]  in_sh [d];
   logic [W-1:0]  acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          xfer;

   // De-interleave the bit-major input into one word per share (wiring only).
   always_comb begin
      in_sh = '{default: '0};
      for (int i = 0; i < d; i++)
         for (int j = 0; j < W; j++)
            in_sh[i][j] = bus.in_shares[j*d + i];
   end

   // Next-state, datapath and handshake outputs; outputs forced idle while in reset.
   always_comb begin
      state_d       = state_q;
      acc_d         = acc_q;
      cnt_d         = cnt_q;
      sh_d          = sh_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_data  = '0;
      bus.busy      = 1'b0;

      if (!rst) begin
         case (state_q)
            IDLE: bus.in_ready = 1'b1;
            ACC:  bus.busy = 1'b1;
            DONE: begin
               bus.busy      = 1'b1;
               bus.out_valid = 1'b1;
               bus.out_data  = acc_q;
               bus.in_ready  = bus.out_ready;
            end
            default: ;
         endcase
      end

      xfer = bus.in_valid & bus.in_ready;

      case (state_q)
         ACC: begin
            acc_d = acc_q ^ sh_q[cnt_q];
            // cnt holds at d-1 on the last fold so it never leaves 0..d-1
            if (cnt_q == CW'(d-1)) state_d = DONE;
            else                   cnt_d   = cnt_q + 1'b1;
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
               acc_d   = '0;
               cnt_d   = '0;
               sh_d    = '{default: '0};
            end
         end
         default: ;
      endcase

      // A new word (from IDLE or as a DONE hand-off) overrides the retire path.
      if (xfer) begin
         sh_d    = in_sh;
         acc_d   = in_sh[0];
         cnt_d   = CW'(1);
         state_d = ACC;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         sh_q    <= '{default: '0};
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
      end
   end
endmodule
